// File: rtl/axi_lite_intr_responder.sv
// AXI4-Lite slave holding the interrupt register file (GIE, IER, ISR, IAR, IPR)
// and driving a single registered irq line from N synchronous interrupt sources.
module axi_lite_intr_responder #(
    parameter int          C_NUM_INTR         = 4,
    parameter int          C_ADDR_WIDTH       = 5,
    parameter int          C_DATA_WIDTH       = 32,
    parameter logic [31:0] C_INTR_SENSITIVITY = 32'hFFFF_FFFF,
    parameter logic        C_IRQ_ACTIVE_STATE = 1'b1
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    input  logic [C_NUM_INTR-1:0]   intr_src,
    output logic                    irq
);

    localparam logic [1:0] WR_IDLE   = 2'd0;
    localparam logic [1:0] WR_ACCEPT = 2'd1;
    localparam logic [1:0] WR_RESP   = 2'd2;

    localparam logic [1:0] RD_IDLE   = 2'd0;
    localparam logic [1:0] RD_ACCEPT = 2'd1;
    localparam logic [1:0] RD_DATA   = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [C_NUM_INTR-1:0] EDGE_SENS = C_INTR_SENSITIVITY[C_NUM_INTR-1:0];

    logic [1:0]            wr_state_q, wr_state_d;
    logic [1:0]            rd_state_q, rd_state_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  gie_q, gie_d;
    logic [C_NUM_INTR-1:0] ier_q, ier_d;
    logic [C_NUM_INTR-1:0] isr_q, isr_d;
    logic [C_NUM_INTR-1:0] src_prev_q;
    logic                  irq_q, irq_d;

    logic [2:0]            wr_idx, rd_idx;
    logic                  wr_fire, rd_fire;
    logic [C_NUM_INTR-1:0] wdata_n, wmask_n;
    logic [C_NUM_INTR-1:0] iar_clr, isr_set;
    logic [31:0]           rd_value;
    logic                  unused_inputs;

    assign wr_idx  = S_AXI_AWADDR[4:2];
    assign rd_idx  = S_AXI_ARADDR[4:2];
    assign wdata_n = S_AXI_WDATA[C_NUM_INTR-1:0];

    // Handshake completes in the cycle the ready pulse is high.
    assign wr_fire = (wr_state_q == WR_ACCEPT) && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_fire = (rd_state_q == RD_ACCEPT) && S_AXI_ARVALID;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                             S_AXI_WDATA, S_AXI_WSTRB};

    always_comb begin
        for (int i = 0; i < C_NUM_INTR; i++) begin
            wmask_n[i] = S_AXI_WSTRB[i / 8];
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID) wr_state_d = WR_ACCEPT;
            WR_ACCEPT: wr_state_d = wr_fire ? WR_RESP : WR_IDLE;
            WR_RESP:   if (S_AXI_BREADY) wr_state_d = WR_IDLE;
            default:   wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE:   if (S_AXI_ARVALID) rd_state_d = RD_ACCEPT;
            RD_ACCEPT: rd_state_d = rd_fire ? RD_DATA : RD_IDLE;
            RD_DATA:   if (S_AXI_RREADY) rd_state_d = RD_IDLE;
            default:   rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        gie_d   = gie_q;
        ier_d   = ier_q;
        iar_clr = '0;
        bresp_d = bresp_q;
        if (wr_fire) begin
            bresp_d = (wr_idx > 3'd4) ? RESP_SLVERR : RESP_OKAY;
            case (wr_idx)
                3'd0:    if (S_AXI_WSTRB[0]) gie_d = S_AXI_WDATA[0];
                3'd1:    ier_d = (ier_q & ~wmask_n) | (wdata_n & wmask_n);
                3'd3:    iar_clr = wdata_n & wmask_n;
                default: ;
            endcase
        end
    end

    // A set in the same cycle as an acknowledge wins, so no event is lost.
    assign isr_set = intr_src & ((EDGE_SENS & ~src_prev_q) | ~EDGE_SENS);
    assign isr_d   = (isr_q & ~iar_clr) | isr_set;
    assign irq_d   = (gie_q && |(isr_q & ier_q)) ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;

    always_comb begin
        rd_value = '0;
        case (rd_idx)
            3'd0:    rd_value[0] = gie_q;
            3'd1:    rd_value[C_NUM_INTR-1:0] = ier_q;
            3'd2:    rd_value[C_NUM_INTR-1:0] = isr_q;
            3'd4:    rd_value[C_NUM_INTR-1:0] = isr_q & ier_q;
            default: rd_value = '0;
        endcase
    end

    // Read data is captured from pre-update state, so a concurrent write is not visible yet.
    assign rdata_d = rd_fire ? rd_value : rdata_q;
    assign rresp_d = rd_fire ? ((rd_idx > 3'd4) ? RESP_SLVERR : RESP_OKAY) : rresp_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            gie_q      <= 1'b0;
            ier_q      <= '0;
            isr_q      <= '0;
            src_prev_q <= '0;
            irq_q      <= ~C_IRQ_ACTIVE_STATE;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            gie_q      <= gie_d;
            ier_q      <= ier_d;
            isr_q      <= isr_d;
            src_prev_q <= intr_src;
            irq_q      <= irq_d;
        end
    end

    assign S_AXI_AWREADY = (wr_state_q == WR_ACCEPT);
    assign S_AXI_WREADY  = (wr_state_q == WR_ACCEPT);
    assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = (rd_state_q == RD_ACCEPT);
    assign S_AXI_RVALID  = (rd_state_q == RD_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_axi_lite_intr_responder.sv
// Randomized bench for axi_lite_intr_responder: directed scenarios plus random bus and
// interrupt traffic, checked against a cycle-level register-file model.
module tb_axi_lite_intr_responder;

    localparam logic [3:0]  SENS  = 4'b1101;   // source 1 is level, others rising-edge
    localparam logic [31:0] NMASK = 32'h0000_000F;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [4:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [4:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [3:0]  intr_src = '0;
    logic        irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        mon_en   = 1'b0;
    logic        rand_src = 1'b0;

    // Reference model state
    logic [31:0] m_gie, m_ier, m_isr, m_prev;
    logic        m_irq;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;

    axi_lite_intr_responder #(
        .C_NUM_INTR         (4),
        .C_ADDR_WIDTH       (5),
        .C_DATA_WIDTH       (32),
        .C_INTR_SENSITIVITY (32'hFFFF_FFFD),
        .C_IRQ_ACTIVE_STATE (1'b1)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .intr_src      (intr_src),
        .irq           (irq)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return m_gie;
            3'd1:    return m_ier;
            3'd2:    return m_isr;
            3'd4:    return m_isr & m_ier;
            default: return 32'h0;
        endcase
    endfunction

    // Model: a register file whose state moves on each clock from the bus handshakes
    // and the sampled sources; irq reflects GIE & |IPR as of the previous cycle.
    always @(posedge ACLK) begin
        logic [31:0] clr, set, bm;
        logic        nxt_irq;
        if (!ARESETN) begin
            m_gie = 0; m_ier = 0; m_isr = 0; m_prev = 0; m_irq = 1'b0;
        end else begin
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                m_rdata = model_read(S_AXI_ARADDR[4:2]);
                m_rresp = (S_AXI_ARADDR[4:2] > 3'd4) ? 2'b10 : 2'b00;
            end
            nxt_irq = (m_gie[0] == 1'b1) && ((m_isr & m_ier) != 0);
            clr = 0;
            if (S_AXI_AWVALID && S_AXI_AWREADY && S_AXI_WVALID && S_AXI_WREADY) begin
                bm = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}}, {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
                case (S_AXI_AWADDR[4:2])
                    3'd0: if (S_AXI_WSTRB[0]) m_gie = S_AXI_WDATA & 32'h1;
                    3'd1: m_ier = ((m_ier & ~bm) | (S_AXI_WDATA & bm)) & NMASK;
                    3'd3: clr = S_AXI_WDATA & bm & NMASK;
                    default: ;
                endcase
            end
            set = 0;
            for (int i = 0; i < 4; i++) begin
                if (SENS[i]) begin
                    if (intr_src[i] && !m_prev[i]) set[i] = 1'b1;
                end else if (intr_src[i]) begin
                    set[i] = 1'b1;
                end
            end
            m_isr  = (m_isr & ~clr) | set;
            m_prev = {28'h0, intr_src};
            m_irq  = nxt_irq;
        end
    end

    always @(negedge ACLK) begin
        if (mon_en) check("irq_model", {31'h0, irq}, {31'h0, m_irq});
    end

    task automatic cyc();
        @(negedge ACLK);
        if (rand_src) intr_src = 4'($urandom);
    endtask

    task automatic wr_issue(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        @(negedge ACLK);
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check("aw_accept", 32'(n < 50), 32'h1);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("awready_pulse", {31'h0, S_AXI_AWREADY}, 32'h0);
    endtask

    task automatic wr_resp(input logic [1:0] exp, input string tag);
        int n = 0;
        S_AXI_BREADY = 1'b1;
        while (!S_AXI_BVALID && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check({tag, "_bvalid"}, {31'h0, S_AXI_BVALID}, 32'h1);
        check({tag, "_bresp"}, {30'h0, S_AXI_BRESP}, {30'h0, exp});
        @(negedge ACLK);
        check({tag, "_bdone"}, {31'h0, S_AXI_BVALID}, 32'h0);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        wr_issue(addr, data, strb);
        wr_resp((addr[4:2] > 3'd4) ? 2'b10 : 2'b00, "wr");
    endtask

    task automatic rd_issue(input logic [4:0] addr);
        int n = 0;
        @(negedge ACLK);
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check("ar_accept", 32'(n < 50), 32'h1);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic rd_resp(output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        S_AXI_RREADY = 1'b1;
        while (!S_AXI_RVALID && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check("rvalid", {31'h0, S_AXI_RVALID}, 32'h1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        check("rdata_model", data, m_rdata);
        check("rresp_model", {30'h0, resp}, {30'h0, m_rresp});
        @(negedge ACLK);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        rd_issue(addr);
        rd_resp(data, resp);
    endtask

    initial begin
        logic [31:0] d, d0;
        logic [1:0]  r;
        int          n;

        // Reset with random source activity
        rand_src = 1'b1;
        cyc();
        mon_en = 1'b1;
        repeat (20) cyc();
        rand_src = 1'b0;
        intr_src = '0;
        cyc();
        check("reset_irq", {31'h0, irq}, 32'h0);
        ARESETN = 1'b1;
        for (int a = 0; a < 5; a++) begin
            axi_read(5'(a * 4), d, r);
            check("reset_rd_data", d, 32'h0);
            check("reset_rd_resp", {30'h0, r}, 32'h0);
        end

        // Enable and fire source 0: irq two cycles after the pulse
        axi_write(5'h00, 32'h1, 4'hF);
        axi_write(5'h04, 32'h1, 4'hF);
        cyc();
        intr_src = 4'b0001;
        cyc();
        intr_src = 4'b0000;
        check("fire_lat1", {31'h0, irq}, 32'h0);
        cyc();
        check("fire_lat2", {31'h0, irq}, 32'h1);
        axi_read(5'h10, d, r);
        check("fire_ipr", d, 32'h1);
        axi_read(5'h08, d, r);
        check("fire_isr", d, 32'h1);

        // Acknowledge
        axi_write(5'h0C, 32'h1, 4'hF);
        check("ack_irq", {31'h0, irq}, 32'h0);
        axi_read(5'h10, d, r);
        check("ack_ipr", d, 32'h0);
        axi_read(5'h0C, d, r);
        check("iar_reads_zero", d, 32'h0);

        // Masking
        axi_write(5'h04, 32'h2, 4'hF);
        cyc();
        intr_src = 4'b0001;
        cyc();
        intr_src = 4'b0000;
        cyc();
        cyc();
        check("mask_irq", {31'h0, irq}, 32'h0);
        axi_read(5'h08, d, r);
        check("mask_isr", d, 32'h1);
        axi_read(5'h10, d, r);
        check("mask_ipr", d, 32'h0);
        axi_write(5'h04, 32'h3, 4'hF);
        check("unmask_irq", {31'h0, irq}, 32'h1);
        axi_write(5'h0C, 32'h1, 4'hF);

        // Level source held high: acknowledge collides with set
        intr_src = 4'b0010;
        repeat (3) cyc();
        axi_write(5'h0C, 32'h2, 4'hF);
        axi_read(5'h08, d, r);
        check("level_collide_isr", d, 32'h2);
        intr_src = 4'b0000;
        cyc();
        axi_write(5'h0C, 32'h2, 4'hF);
        axi_read(5'h08, d, r);
        check("level_cleared_isr", d, 32'h0);

        // Out-of-range decode
        wr_issue(5'h14, 32'hFFFF_FFFF, 4'hF);
        wr_resp(2'b10, "slverr");
        axi_read(5'h1C, d, r);
        check("slverr_rdata", d, 32'h0);
        check("slverr_rresp", {30'h0, r}, 32'h2);
        axi_read(5'h00, d, r);
        check("slverr_gie_kept", d, 32'h1);

        // Zero strobes: no-op
        axi_write(5'h00, 32'h0, 4'h0);
        axi_read(5'h00, d, r);
        check("nostrb_gie", d, 32'h1);

        // Concurrent write and read of IER: read sees pre-write value
        fork
            begin wr_issue(5'h04, 32'h1, 4'hF); wr_resp(2'b00, "conc"); end
            begin rd_issue(5'h04); rd_resp(d, r); end
        join
        check("conc_pre_write", d, 32'h3);
        axi_read(5'h04, d, r);
        check("conc_post_write", d, 32'h1);

        // Write backpressure: second write held off while BVALID is high
        S_AXI_BREADY = 1'b0;
        wr_issue(5'h04, 32'h3, 4'hF);
        S_AXI_AWADDR = 5'h04; S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (!S_AXI_BVALID || S_AXI_BRESP != 2'b00 || S_AXI_AWREADY) n++;
        end
        check("bp_write_hold", n, 0);
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        check("bp_b_done", {31'h0, S_AXI_BVALID}, 32'h0);
        wr_issue(5'h04, 32'h5, 4'hF);
        wr_resp(2'b00, "bp2");
        axi_read(5'h04, d, r);
        check("bp_second_write", d, 32'h5);

        // Read backpressure
        S_AXI_RREADY = 1'b0;
        rd_issue(5'h04);
        d0 = S_AXI_RDATA;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (!S_AXI_RVALID || S_AXI_RDATA != 32'h5 || S_AXI_RRESP != 2'b00) n++;
        end
        check("bp_read_hold", n, 0);
        check("bp_read_data", d0, 32'h5);
        rd_resp(d, r);

        // Random traffic
        rand_src = 1'b1;
        for (int it = 0; it < 400; it++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 7) * 4);
            case ($urandom_range(0, 3))
                0: axi_write(a, $urandom, 4'($urandom));
                1: axi_read(a, d, r);
                2: fork
                       begin wr_issue(a, $urandom & 32'hF, 4'hF); wr_resp((a[4:2] > 3'd4) ? 2'b10 : 2'b00, "rconc"); end
                       begin rd_issue(5'($urandom_range(0, 7) * 4)); rd_resp(d, r); end
                   join
                default: repeat ($urandom_range(1, 4)) cyc();
            endcase
        end
        rand_src = 1'b0;
        intr_src = '0;

        // Reset during an accepted write address phase aborts it
        @(negedge ACLK);
        S_AXI_AWADDR = 5'h00; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        ARESETN = 1'b0;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        repeat (3) cyc();
        ARESETN = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) n++;
        end
        check("abort_no_bvalid", n, 0);
        axi_read(5'h00, d, r);
        check("abort_gie", d, 32'h0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
